// File: rtl/uart_rx_if.sv
// uart_rx_if -- byte stream handshake between the UART receiver and its consumer.
//   rx_data  : byte at the receive FIFO head (meaningful only while rx_valid=1)
//   rx_valid : receive FIFO holds at least one byte
//   rx_ready : consumer takes rx_data on any cycle where rx_valid and rx_ready are both 1
// The master modport is the receiver side; the slave modport is the consumer side.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a small receive FIFO.
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-high
//   rxd        : asynchronous serial line, idle high, LSB first
//   rx_bus     : byte stream out (rx_data / rx_valid / rx_ready)
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overrun    : one-cycle pulse when a completed byte is dropped on a full FIFO
//   fifo_level : current FIFO occupancy, 0..FIFO_DEPTH
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rxd,
  uart_rx_if.master                     rx_bus,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic [2:0]      bit_idx, bit_idx_nx;
  logic [7:0]      shift, shift_nx;
  logic            push, ferr_nx;
  logic            rxd_p0, rxd_p1;
  logic            rxs;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count;
  logic            full, pop, do_push;

  // ---- stage p0/p1: two-flop synchronizer on the raw line ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  assign rxs = rxd_p1;

  // ---- frame FSM: state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= bit_idx_nx;
    end
  end

  // Shift register carries data only; a reset mid-frame simply abandons it.
  always_ff @(posedge clk) begin
    shift <= shift_nx;
  end

  // START samples at mid-bit; from then on every sample lands one full bit later,
  // so all data and stop samples sit near the centre of their bit cells.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer + 1'b1;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    push       = 1'b0;
    ferr_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_nx = '0;
        if (!rxs) state_nx = START;
      end
      START: begin
        if (timer == HALF_END) begin
          timer_nx = '0;
          if (!rxs) begin
            state_nx   = DATA;
            bit_idx_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      DATA: begin
        if (timer == BIT_END) begin
          timer_nx          = '0;
          shift_nx[bit_idx] = rxs;
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_idx_nx = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (timer == BIT_END) begin
          timer_nx = '0;
          if (rxs) begin
            push     = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx  = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must return high before a new start edge counts.
        timer_nx = '0;
        if (rxs) state_nx = IDLE;
      end
      default: begin
        timer_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // ---- receive FIFO: push on the stop-bit sample edge ----
  assign full    = (count == FULL_LVL);
  assign pop     = rx_bus.rx_valid && rx_bus.rx_ready;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_nx;
      overrun   <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Memory is not cleared by reset, so mask the head while empty to keep rx_data at 0.
  assign rx_bus.rx_valid = (count != '0);
  assign rx_bus.rx_data  = rx_bus.rx_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_level      = count;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive FIFO entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rxd  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 rx_data  output  8  byte at FIFO head; valid only while rx_valid=1.
REQ-007 rx_valid  output  1  FIFO non-empty.
REQ-008 rx_ready  input  1  consumer accepts rx_data on a cycle where rx_valid=1 and rx_ready=1.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed byte dropped because FIFO full.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer (flops reset to 1); all FSM decisions use the synchronized value rxs.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH; single bit-timer counter 0..CLKS_PER_BIT-1; bit index 0..7.
REQ-014 IDLE: on rxs=0 -> START, timer cleared.
REQ-015 START: when timer reaches CLKS_PER_BIT/2-1 (integer divide), sample rxs; 0 -> DATA, timer cleared, bit index 0; 1 -> IDLE (glitch rejected, no output, no pulse).
REQ-016 DATA: when timer reaches CLKS_PER_BIT-1, sample rxs into shift register bit position [index], timer cleared; after index 7 -> STOP.
REQ-017 STOP: when timer reaches CLKS_PER_BIT-1, sample rxs; 1 -> push byte, go IDLE; 0 -> pulse frame_err, discard byte, go WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until rxs=1, then IDLE; break conditions produce exactly one frame_err.
REQ-019 Push occurs on the cycle after the stop-bit sample; rx_valid SHALL rise on that same push edge when FIFO was empty (visible one cycle after the sample cycle).
REQ-020 Pop occurs on any cycle with rx_valid=1 and rx_ready=1; rx_data then shows the next entry the following cycle.
REQ-021 Push when full and no pop: byte dropped, overrun pulses one cycle, FIFO contents unchanged.
REQ-022 Push and pop in the same cycle: both take effect, fifo_level unchanged, no overrun, including when full.
REQ-023 Pop when empty: ignored (rx_valid=0 guarantees none).
REQ-024 FIFO pointers wrap modulo FIFO_DEPTH; fifo_level never exceeds FIFO_DEPTH nor underflows.
REQ-025 frame_err and overrun cannot coincide (different cycles by construction); each is registered.
REQ-026 rx_ready is ignored while rx_valid=0; rx_data undefined while rx_valid=0 but held stable while rx_valid=1 and not popped.

Reset
REQ-027 reset=1 SHALL immediately force: FSM IDLE, timer 0, bit index 0, synchronizer flops 1, FIFO empty, rx_valid 0, fifo_level 0, frame_err 0, overrun 0, rx_data 0.
REQ-028 Reset asserted mid-frame discards the partial byte; after release the block waits for rxs high-to-low before starting a new frame (a line held low at release is treated as a start edge only after passing START validation).
REQ-029 Reset deassertion is synchronized externally; no behaviour required within two cycles of release beyond REQ-027 values.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-030 Send 0xA5 8N1, rx_ready=1 -> rx_valid high one cycle with rx_data=0xA5, fifo_level returns 0, no pulses.
REQ-031 Send 0x00 with stop bit low, then line low 40 cycles, then high -> one frame_err pulse, no rx_valid, next byte 0x3C received correctly.
REQ-032 rx_ready=0, send 0x01..0x05 -> fifo_level=4, overrun pulses once on 5th byte; then rx_ready=1 -> pops 0x01,0x02,0x03,0x04 in order.
REQ-033 FIFO full, raise rx_ready exactly on 5th byte's push cycle -> no overrun, fifo_level stays 4, final contents 0x02..0x05.
REQ-034 rxd low pulse of 5 cycles in IDLE -> returns IDLE, no output; assert reset during bit 4 of 0xFF -> all outputs zero, next 0x81 received correctly.
